// File: rtl/ir_rx_decoder.sv
// ir_rx_decoder: NEC-format IR receive decoder.
// Takes the demodulated, active-low output of an external 38 kHz IR receiver.
// It measures mark and space durations in quarter-unit (Q) ticks and decodes:
//   - 32-bit frames (LSB first),
//   - repeat codes,
//   - out-of-window and timeout errors.
// Optional build macro IR_RX_CHECK_EN: reject frames whose address/command
// bytes are not followed by their bitwise inverses.
module ir_rx_decoder #(
    parameter int PRESC  = 1688,
    parameter int TOUT_Q = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_rx,
    input  logic        en,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_rpt,
    output logic        rx_err,
    output logic        rx_busy
);

    localparam int              PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);
    localparam logic [7:0]      TOUT_LIM   = 8'(TOUT_Q);

    // Acceptance windows in Q, inclusive
    localparam logic [7:0] LEAD_MARK_LO  = 8'd56;
    localparam logic [7:0] LEAD_MARK_HI  = 8'd72;
    localparam logic [7:0] LEAD_SPACE_LO = 8'd28;
    localparam logic [7:0] LEAD_SPACE_HI = 8'd36;
    localparam logic [7:0] RPT_SPACE_LO  = 8'd13;
    localparam logic [7:0] RPT_SPACE_HI  = 8'd19;
    localparam logic [7:0] SHORT_LO      = 8'd2;   // bit mark, "0" space, stop mark
    localparam logic [7:0] SHORT_HI      = 8'd6;
    localparam logic [7:0] ONE_SPACE_LO  = 8'd10;
    localparam logic [7:0] ONE_SPACE_HI  = 8'd14;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_STOP
    } state_t;

    state_t         state_reg;
    logic [2:0]     sync_reg;      // [0],[1] synchronizer, [2] previous synced value
    logic [PW-1:0]  presc_reg;
    logic [7:0]     q_reg;
    logic [31:0]    shift_reg;
    logic [4:0]     bit_idx_reg;
    logic [31:0]    rx_data_reg;
    logic           rx_valid_reg;
    logic           rx_rpt_reg;
    logic           rx_err_reg;
    logic           rx_busy_reg;

    logic           edge_fall;
    logic           edge_rise;
    logic           edge_any;
    logic           timed_out;

    // Falling edge on the synced input is the start of a mark (carrier on)
    assign edge_fall = sync_reg[2] & ~sync_reg[1];
    assign edge_rise = ~sync_reg[2] & sync_reg[1];
    assign edge_any  = edge_fall | edge_rise;
    assign timed_out = (q_reg > TOUT_LIM);

    function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Two-flop synchronizer plus a history flop for edge detection; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], ir_rx};
        end
    end

    // Prescaler and saturating Q counter, both restarted by every synced edge
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            q_reg     <= 8'd0;
        end else if (edge_any) begin
            presc_reg <= '0;
            q_reg     <= 8'd0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
            if (q_reg != 8'hFF) begin
                q_reg <= q_reg + 8'd1;
            end
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Frame FSM with registered event pulses, busy flag and data register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= 32'd0;
            bit_idx_reg  <= 5'd0;
            rx_data_reg  <= 32'd0;
            rx_valid_reg <= 1'b0;
            rx_rpt_reg   <= 1'b0;
            rx_err_reg   <= 1'b0;
            rx_busy_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            rx_rpt_reg   <= 1'b0;
            rx_err_reg   <= 1'b0;
            if (!en) begin
                // Disabling is a silent abort: no error pulse, data held
                state_reg   <= IDLE;
                rx_busy_reg <= 1'b0;
            end else if ((state_reg != IDLE) && timed_out) begin
                rx_err_reg  <= 1'b1;
                state_reg   <= IDLE;
                rx_busy_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (edge_fall) begin
                            state_reg   <= LEAD_MARK;
                            rx_busy_reg <= 1'b1;
                        end
                    end
                    LEAD_MARK: begin
                        if (edge_rise) begin
                            if (in_win(q_reg, LEAD_MARK_LO, LEAD_MARK_HI)) begin
                                state_reg <= LEAD_SPACE;
                            end else begin
                                rx_err_reg  <= 1'b1;
                                state_reg   <= IDLE;
                                rx_busy_reg <= 1'b0;
                            end
                        end
                    end
                    LEAD_SPACE: begin
                        if (edge_fall) begin
                            if (in_win(q_reg, LEAD_SPACE_LO, LEAD_SPACE_HI)) begin
                                bit_idx_reg <= 5'd0;
                                state_reg   <= BIT_MARK;
                            end else if (in_win(q_reg, RPT_SPACE_LO, RPT_SPACE_HI)) begin
                                state_reg <= RPT_STOP;
                            end else begin
                                rx_err_reg  <= 1'b1;
                                state_reg   <= IDLE;
                                rx_busy_reg <= 1'b0;
                            end
                        end
                    end
                    BIT_MARK: begin
                        if (edge_rise) begin
                            if (in_win(q_reg, SHORT_LO, SHORT_HI)) begin
                                state_reg <= BIT_SPACE;
                            end else begin
                                rx_err_reg  <= 1'b1;
                                state_reg   <= IDLE;
                                rx_busy_reg <= 1'b0;
                            end
                        end
                    end
                    BIT_SPACE: begin
                        // Space length encodes the bit; first bit ends up in bit 0
                        if (edge_fall) begin
                            if (in_win(q_reg, SHORT_LO, SHORT_HI) ||
                                in_win(q_reg, ONE_SPACE_LO, ONE_SPACE_HI)) begin
                                shift_reg <= {in_win(q_reg, ONE_SPACE_LO, ONE_SPACE_HI),
                                              shift_reg[31:1]};
                                if (bit_idx_reg == 5'd31) begin
                                    state_reg <= STOP_MARK;
                                end else begin
                                    bit_idx_reg <= bit_idx_reg + 5'd1;
                                    state_reg   <= BIT_MARK;
                                end
                            end else begin
                                rx_err_reg  <= 1'b1;
                                state_reg   <= IDLE;
                                rx_busy_reg <= 1'b0;
                            end
                        end
                    end
                    STOP_MARK: begin
                        if (edge_rise) begin
                            state_reg   <= IDLE;
                            rx_busy_reg <= 1'b0;
                            if (in_win(q_reg, SHORT_LO, SHORT_HI)) begin
`ifdef IR_RX_CHECK_EN
                                if ((shift_reg[15:8] == ~shift_reg[7:0]) &&
                                    (shift_reg[31:24] == ~shift_reg[23:16])) begin
                                    rx_data_reg  <= shift_reg;
                                    rx_valid_reg <= 1'b1;
                                end else begin
                                    rx_err_reg <= 1'b1;
                                end
`else
                                rx_data_reg  <= shift_reg;
                                rx_valid_reg <= 1'b1;
`endif
                            end else begin
                                rx_err_reg <= 1'b1;
                            end
                        end
                    end
                    RPT_STOP: begin
                        if (edge_rise) begin
                            state_reg   <= IDLE;
                            rx_busy_reg <= 1'b0;
                            if (in_win(q_reg, SHORT_LO, SHORT_HI)) begin
                                rx_rpt_reg <= 1'b1;
                            end else begin
                                rx_err_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        rx_busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_rpt   = rx_rpt_reg;
    assign rx_err   = rx_err_reg;
    assign rx_busy  = rx_busy_reg;

endmodule

// File: tb/tb_ir_rx_decoder.sv
// Directed testbench for ir_rx_decoder with PRESC = 4 (Q = 4 clk).
// Checks reset, good frames, repeats, bad bits, timeouts, the optional
// inversion check (IR_RX_CHECK_EN), mid-frame reset and enable.
module tb_ir_rx_decoder;

    localparam int QC = 4;

    logic        clk;
    logic        rst;
    logic        ir_rx;
    logic        en;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_rpt;
    logic        rx_err;
    logic        rx_busy;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_rpt   = 0;
    int n_err   = 0;
    logic [31:0] exp_data;

    ir_rx_decoder #(.PRESC(4), .TOUT_Q(80)) dut (
        .clk      (clk),
        .rst      (rst),
        .ir_rx    (ir_rx),
        .en       (en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_rpt   (rx_rpt),
        .rx_err   (rx_err),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled 2 ns after each rising edge
    always @(posedge clk) begin
        #2;
        if (rx_valid === 1'b1) n_valid++;
        if (rx_rpt === 1'b1)   n_rpt++;
        if (rx_err === 1'b1)   n_err++;
    end

    // Hold ir_rx at lvl for nq quarter-units; called and returns at a negedge
    task automatic hold(input logic lvl, input int nq);
        ir_rx = lvl;
        repeat (nq * QC) @(negedge clk);
    endtask

    // Leader followed by the first nbits data bits; leaves the line high
    task automatic send_head(input logic [31:0] d, input int nbits);
        hold(1'b0, 64);
        hold(1'b1, 32);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 4);
            hold(1'b1, d[i] ? 12 : 4);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; ir_rx = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (rx_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=%h", rx_data, 32'd0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_rpt !== 1'b0) begin bad++; $display("FAIL reset_rpt got=%b exp=0", rx_rpt); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rx_err); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", rx_busy); end
        exp_data = 32'd0;
        $display("tx reset done data=%h", rx_data);
    endtask

    // Full frame; checks the rx_valid pulse lands exactly 3 clk after the final rise
    task automatic test_good_frame(input logic [31:0] d, input string nm);
        int  v0, r0, e0;
        logic early;
        v0 = n_valid; r0 = n_rpt; e0 = n_err;
        send_head(d, 32);
        hold(1'b0, 4);
        ir_rx = 1'b1;
        early = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rx_valid !== 1'b0) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL %s_early got=1 exp=0", nm); end
        @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", nm, rx_valid); end
        total++; if (rx_data !== d) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, rx_data, d); end
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse_width got=%b exp=0", nm, rx_valid); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", nm, rx_busy); end
        hold(1'b1, 10);
        total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL %s_valid_count got=%0d exp=%0d", nm, n_valid, v0 + 1); end
        total++; if ((n_err !== e0) || (n_rpt !== r0)) begin bad++; $display("FAIL %s_side_pulses got=%0d/%0d exp=%0d/%0d", nm, n_err, n_rpt, e0, r0); end
        exp_data = d;
        $display("tx %s frame sent=%h rx_data=%h", nm, d, rx_data);
    endtask

    task automatic test_repeat;
        int  v0;
        logic early;
        v0 = n_valid;
        hold(1'b0, 64);
        hold(1'b1, 16);
        hold(1'b0, 4);
        ir_rx = 1'b1;
        early = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rx_rpt !== 1'b0) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL rpt_early got=1 exp=0"); end
        @(negedge clk);
        total++; if (rx_rpt !== 1'b1) begin bad++; $display("FAIL rpt_pulse got=%b exp=1", rx_rpt); end
        @(negedge clk);
        total++; if (rx_rpt !== 1'b0) begin bad++; $display("FAIL rpt_width got=%b exp=0", rx_rpt); end
        hold(1'b1, 10);
        total++; if (rx_data !== exp_data) begin bad++; $display("FAIL rpt_data got=%h exp=%h", rx_data, exp_data); end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL rpt_no_valid got=%0d exp=%0d", n_valid, v0); end
        $display("tx repeat code rx_data=%h", rx_data);
    endtask

    // Bit 5 space of 8Q lies between the "0" and "1" windows
    task automatic test_bad_bit;
        int v0;
        logic early;
        v0 = n_valid;
        send_head(32'hA5A5_5A5A, 5);
        hold(1'b0, 4);
        hold(1'b1, 8);
        ir_rx = 1'b0;
        early = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rx_err !== 1'b0) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL badbit_early got=1 exp=0"); end
        @(negedge clk);
        total++; if (rx_err !== 1'b1) begin bad++; $display("FAIL badbit_err got=%b exp=1", rx_err); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL badbit_busy got=%b exp=0", rx_busy); end
        hold(1'b0, 3);
        hold(1'b1, 20);
        total++; if (rx_data !== exp_data) begin bad++; $display("FAIL badbit_data got=%h exp=%h", rx_data, exp_data); end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL badbit_no_valid got=%0d exp=%0d", n_valid, v0); end
        $display("tx bad bit 5 rx_err seen, rx_data=%h", rx_data);
    endtask

    task automatic test_check;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_head(32'h00FF_00FE, 32);
        hold(1'b0, 4);
        hold(1'b1, 10);
`ifdef IR_RX_CHECK_EN
        total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL check_err got=%0d exp=%0d", n_err, e0 + 1); end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL check_no_valid got=%0d exp=%0d", n_valid, v0); end
`else
        total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL check_valid got=%0d exp=%0d", n_valid, v0 + 1); end
        total++; if (n_err !== e0) begin bad++; $display("FAIL check_no_err got=%0d exp=%0d", n_err, e0); end
        exp_data = 32'h00FF_00FE;
`endif
        total++; if (rx_data !== exp_data) begin bad++; $display("FAIL check_data got=%h exp=%h", rx_data, exp_data); end
        $display("tx check frame sent=00ff00fe rx_data=%h", rx_data);
    endtask

    task automatic test_timeout;
        int e0;
        e0 = n_err;
        hold(1'b0, 64);
        hold(1'b1, 76);
        total++; if (n_err !== e0) begin bad++; $display("FAIL tout_early got=%0d exp=%0d", n_err, e0); end
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL tout_busy_before got=%b exp=1", rx_busy); end
        hold(1'b1, 24);
        total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL tout_space got=%0d exp=%0d", n_err, e0 + 1); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL tout_busy_after got=%b exp=0", rx_busy); end
        hold(1'b0, 300);
        total++; if (n_err !== e0 + 2) begin bad++; $display("FAIL tout_stuck_low got=%0d exp=%0d", n_err, e0 + 2); end
        hold(1'b1, 20);
        total++; if (n_err !== e0 + 2) begin bad++; $display("FAIL tout_release got=%0d exp=%0d", n_err, e0 + 2); end
        $display("tx timeout and stuck-low errors=%0d", n_err - e0);
    endtask

    task automatic test_reset_mid;
        send_head(32'h0F0F_1234, 12);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", rx_busy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy); end
        total++; if (rx_data !== 32'd0) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", rx_data, 32'd0); end
        total++; if ({rx_valid, rx_rpt, rx_err} !== 3'b000) begin bad++; $display("FAIL rstmid_pulses got=%b exp=000", {rx_valid, rx_rpt, rx_err}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 10);
        exp_data = 32'd0;
        $display("tx reset at bit 12 rx_data=%h", rx_data);
    endtask

    task automatic test_enable;
        int e0;
        e0 = n_err;
        send_head(32'hDEAD_BEEF, 10);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL en_busy_before got=%b exp=1", rx_busy); end
        en = 1'b0;
        @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL en_busy_drop got=%b exp=0", rx_busy); end
        hold(1'b1, 20);
        en = 1'b1;
        hold(1'b1, 4);
        total++; if (n_err !== e0) begin bad++; $display("FAIL en_no_err got=%0d exp=%0d", n_err, e0); end
        $display("tx enable dropped mid-frame busy=%b", rx_busy);
        test_good_frame(32'h1234_5678, "after_en");
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ir_rx = 1'b1;
        exp_data = 32'd0;
        test_reset;
        test_good_frame(32'hED12_BF40, "good");
        test_repeat;
        test_bad_bit;
        test_check;
        test_timeout;
        test_reset_mid;
        test_enable;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_rx_decoder.md
Name: ir_rx_decoder

Overview:
- Receive-side counterpart of the IR LED transmit path.
- Accepts the demodulated, active-low output of an external 38 kHz IR receiver module on a GPIO pad.
- Measures mark/space durations and decodes NEC-format frames: a 32-bit word, repeat codes and error indications.
- Sits between the IR input pad and the SoC register/interrupt fabric.

Parameters:
PRESC, 1688, system clocks per quarter-unit Q (T = 562.5 us = 4Q; 1688 gives Q at 12 MHz)
TOUT_Q, 80, any mark, or any non-idle space, longer than this many Q aborts the frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ir_rx  input  1  demodulated IR input, asynchronous, low = carrier present (mark)
en  input  1  decoder enable; 0 holds FSM in IDLE
rx_data  output  32  last good frame, bit 0 = first received bit
rx_valid  output  1  one-cycle pulse: new frame on rx_data
rx_rpt  output  1  one-cycle pulse: NEC repeat code received
rx_err  output  1  one-cycle pulse: frame aborted
rx_busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: rx_data = 0, rx_valid = rx_rpt = rx_err = 0, rx_busy = 0. FSM = IDLE, counters = 0, sync flops = 1.
- Input conditioning:
  - 2-flop synchronizer on ir_rx; edge detect on the synced value.
  - Pad-to-edge latency is 2 clk.
- Timing:
  - Prescaler counts 0..PRESC-1 and restarts at 0 on every synced edge.
  - 8-bit Q counter increments on each prescaler wrap, saturates at 255, and clears on every edge.
  - Each duration is sampled as the Q count at the terminating edge.
- Acceptance windows, inclusive, in Q:
  - leader mark 56..72
  - leader space 28..36
  - repeat space 13..19
  - bit mark 2..6
  - space "0" 2..6
  - space "1" 10..14
  - stop mark 2..6
- FSM states:
  - IDLE: waits for a falling edge, then goes to LEAD_MARK.
  - LEAD_MARK: on a rising edge, duration in window goes to LEAD_SPACE; otherwise error.
  - LEAD_SPACE: on a falling edge:
    - leader-space window: clear bit index, go to BIT_MARK.
    - repeat window: go to RPT_STOP.
    - otherwise: error.
  - BIT_MARK: on a rising edge, in-window goes to BIT_SPACE; otherwise error.
  - BIT_SPACE: on a falling edge:
    - "0" window shifts in 0; "1" window shifts in 1; otherwise error.
    - Shift is LSB-first into a shift register.
    - Bit index 31 goes to STOP_MARK; else index+1 and back to BIT_MARK.
  - STOP_MARK: on a rising edge, in-window loads rx_data from the shift register and pulses rx_valid; otherwise error. Return to IDLE.
  - RPT_STOP: on a rising edge, in-window pulses rx_rpt; otherwise error. Return to IDLE.
- Error rule: any out-of-window duration pulses rx_err and returns to IDLE; rx_data is unchanged.
- Timeout:
  - Q count > TOUT_Q while in any state except IDLE pulses rx_err and returns to IDLE.
  - If the input is still low after a timeout, IDLE waits for the next falling edge; a stuck-low input produces one error only.
- Output timing: rx_valid, rx_rpt and rx_err are registered and assert 3 clk after the pad edge that completes the event. At most one of them is high in any cycle.
- en = 0:
  - FSM is forced to IDLE next cycle with no error pulse; rx_data is held.
  - A frame already in progress when en rises is ignored until the next IDLE falling edge.
- rst mid-frame: all state and outputs return to reset values next cycle.
- rx_busy = (state != IDLE), registered.

Optional Feature:
- Macro: IR_RX_CHECK_EN.
- Defined: at STOP_MARK acceptance, require rx_data[15:8] == ~rx_data[7:0] and rx_data[31:24] == ~rx_data[23:16]. On mismatch, pulse rx_err instead of rx_valid and leave rx_data unchanged.
- Undefined: no inversion check; any well-timed frame pulses rx_valid.

Test Plan:
- All scenarios use PRESC = 4, so Q = 4 clk.
- Good frame: leader 64Q low / 32Q high, then 32 bits of 0xED12BF40 (4Q mark; 4Q/12Q space), stop 4Q low -> rx_valid for 1 clk 3 clk after the final rise, rx_data = 0xED12BF40 (passes the check, macro on or off).
- Repeat: 64Q low / 16Q high / 4Q low -> rx_rpt pulse; rx_data keeps its previous value; no rx_valid.
- Bad bit: bit 5 space = 8Q -> rx_err pulse at that falling edge; FSM back in IDLE; rx_data unchanged.
- Timeout and stuck-low: after the leader, hold ir_rx high for 100Q -> rx_err when the count passes 80Q. Then hold low for 300Q -> exactly one further rx_err.
- Check feature: frame 0x00FF00FE with IR_RX_CHECK_EN -> rx_err, no rx_valid. Without the macro -> rx_valid with rx_data = 0x00FF00FE.
- Reset/enable: assert rst at bit 12 -> all outputs 0 next clk. Deassert en mid-frame -> rx_busy drops next clk with no rx_err; the following frame decodes normally.
